// File: rtl/mul_div_unit_pkg.sv
// Shared multiply/divide definitions: funct3 op codes, FSM state encoding and
// small decode helpers used by the iterative RV32M unit.
package mul_div_unit_pkg;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  // All divide/remainder codes share bit 2; remainder codes also set bit 1.
  function automatic logic md_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic md_is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  function automatic logic md_op1_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic md_op2_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/mul_div_unit_sign_fix.sv
// Conditional two's-complement negation of a double-width raw result; shared by
// the product and the quotient/remainder paths.
module md_sign_fix #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] raw,
  input  logic              negate,
  output logic [2*XLEN-1:0] fixed
);

  localparam logic [2*XLEN-1:0] ONE = {{(2*XLEN-1){1'b0}}, 1'b1};

  assign fixed = negate ? (~raw + ONE) : raw;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with a final sign-correction cycle.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e             state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic                  neg_q, neg_d;
  logic [XLEN-1:0]       opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]     acc_q, acc_d;
  logic [XLEN-1:0]       rem_q, rem_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [XLEN-1:0]       result_q, result_d;

  // Accept-time decode of the incoming request.
  logic                  op1_neg, op2_neg;
  logic [XLEN-1:0]       op1_mag, op2_mag;
  logic                  div_by_zero, signed_ovf;

  assign op1_neg     = md_op1_signed(op) & operand1[XLEN-1];
  assign op2_neg     = md_op2_signed(op) & operand2[XLEN-1];
  assign op1_mag     = op1_neg ? (~operand1 + ONE) : operand1;
  assign op2_mag     = op2_neg ? (~operand2 + ONE) : operand2;
  assign div_by_zero = md_is_div(op) && (operand2 == '0);
  assign signed_ovf  = ((op == MD_DIV) || (op == MD_REM)) &&
                       (operand1 == MIN_INT) && (operand2 == '1);

  // One multiply step: conditionally add the multiplicand to the upper half, then
  // shift the whole accumulator right, carry included.
  logic [XLEN:0]         mul_sum;
  logic [2*XLEN-1:0]     mul_next;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // One restoring-divide step; the extra top bit of the difference is the guard
  // that tells whether the trial subtraction borrowed.
  logic [XLEN:0]         div_shifted, div_diff;
  logic                  q_bit;

  assign div_shifted = {rem_q, acc_q[XLEN-1]};
  assign div_diff    = div_shifted - {1'b0, opnd_q};
  assign q_bit       = ~div_diff[XLEN];

  logic [2*XLEN-1:0]     fix_raw, fix_out;
  logic [XLEN-1:0]       fix_sel;

  assign fix_raw = !md_is_div(op_q) ? acc_q :
                   {{XLEN{1'b0}}, (md_is_rem(op_q) ? rem_q : acc_q[XLEN-1:0])};

  md_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .raw    (fix_raw),
    .negate (neg_q),
    .fixed  (fix_out)
  );

  assign fix_sel = (md_is_div(op_q) || (op_q == MD_MUL)) ? fix_out[XLEN-1:0]
                                                         : fix_out[2*XLEN-1:XLEN];

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    if (flush) begin
      state_d = MD_IDLE;
    end else begin
      unique case (state_q)
        MD_IDLE: begin
          if (in_valid) begin
            op_d   = op;
            // Remainder follows the dividend's sign; otherwise signs differing negates.
            neg_d  = md_is_rem(op) ? op1_neg : (op1_neg ^ op2_neg);
            opnd_d = md_is_div(op) ? op2_mag : op1_mag;
            acc_d  = {{XLEN{1'b0}}, (md_is_div(op) ? op1_mag : op2_mag)};
            rem_d  = '0;
            cnt_d  = CNT_W'(XLEN - 1);
            if (div_by_zero) begin
              result_d = md_is_rem(op) ? operand1 : '1;
              state_d  = MD_DONE;
            end else if (signed_ovf) begin
              result_d = md_is_rem(op) ? '0 : MIN_INT;
              state_d  = MD_DONE;
            end else begin
              state_d  = MD_CALC;
            end
          end
        end
        MD_CALC: begin
          if (md_is_div(op_q)) begin
            rem_d = q_bit ? div_diff[XLEN-1:0] : div_shifted[XLEN-1:0];
            acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], q_bit};
          end else begin
            acc_d = mul_next;
          end
          if (cnt_q == '0) begin
            state_d = MD_FIX;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        MD_FIX: begin
          result_d = fix_sel;
          state_d  = MD_DONE;
        end
        MD_DONE: begin
          if (out_ready) state_d = MD_IDLE;
        end
        default: state_d = MD_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // NOTE: datapath registers are deliberately left without reset; they are always
  // loaded on accept before being used, so resetting them only costs routing.
  always_ff @(posedge clk) begin
    op_q   <= op_d;
    neg_q  <= neg_d;
    opnd_q <= opnd_d;
    acc_q  <= acc_d;
    rem_q  <= rem_d;
  end

  assign in_ready  = (state_q == MD_IDLE);
  assign busy      = (state_q != MD_IDLE);
  assign out_valid = (state_q == MD_DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: arithmetic vectors, special-case
// fast path, latency, backpressure, flush and reset behaviour.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]      op;
  logic [XLEN-1:0] operand1, operand2, result;

  int n_checks = 0;
  int n_pass   = 0;
  logic [XLEN-1:0] last_res;

  mul_div_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .operand1  (operand1),
    .operand2  (operand2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one op, measure cycles from accept to out_valid, check result, hold
  // backpressure for 'hold' cycles, then consume.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int exp_lat, input int hold);
    int lat;
    op = o; operand1 = a; operand2 = b; in_valid = 1'b1;
    check({tag, "/in_ready"}, {31'b0, in_ready}, 32'd1);
    tick;
    in_valid = 1'b0;
    operand1 = '0; operand2 = '0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick;
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/result"}, result, exp);
    for (int i = 0; i < hold; i++) begin
      tick;
      check({tag, "/hold_result"}, result, exp);
      check({tag, "/hold_in_ready"}, {31'b0, in_ready}, 32'd0);
      check({tag, "/hold_valid"}, {31'b0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check({tag, "/valid_drop"}, {31'b0, out_valid}, 32'd0);
    check({tag, "/in_ready_back"}, {31'b0, in_ready}, 32'd1);
    last_res = exp;
  endtask

  initial begin
    int lat;
    logic seen_valid;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = MD_MUL; operand1 = '0; operand2 = '0;
    tick; tick;
    rst = 1'b0;
    check("reset/in_ready", {31'b0, in_ready}, 32'd1);
    check("reset/out_valid", {31'b0, out_valid}, 32'd0);
    check("reset/busy", {31'b0, busy}, 32'd0);
    check("reset/result", result, 32'd0);
    last_res = 32'd0;

    // Arithmetic vectors, normal path (XLEN+2 cycles to out_valid).
    run_op("mulhu_ff",  MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0);
    run_op("mul_ff",    MD_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34, 0);
    run_op("mulh_min",  MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0);
    run_op("mulhsu_ff", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0);
    run_op("mulh_m3x5", MD_MULH,   32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 34, 0);
    run_op("mul_m3x5",  MD_MUL,    32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 34, 0);
    run_op("div_m7_2",  MD_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 0);
    run_op("rem_m7_2",  MD_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 0);
    run_op("div_7_m2",  MD_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 0);
    run_op("rem_7_m2",  MD_REM,    32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 34, 0);
    run_op("divu_100",  MD_DIVU,   32'd100,       32'd7,         32'd14,        34, 0);
    run_op("remu_100",  MD_REMU,   32'd100,       32'd7,         32'd2,         34, 0);

    // Special cases take the fast path.
    run_op("div_by0",   MD_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1, 0);
    run_op("remu_by0",  MD_REMU,   32'd5,         32'd0,         32'd5,         1, 0);
    run_op("div_ovf",   MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("rem_ovf",   MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);

    // Backpressure: result and handshake held for 10 cycles in DONE.
    run_op("bp_divu",   MD_DIVU,   32'd1000,      32'd3,         32'd333,       34, 10);

    // Flush during CALC cycle 5.
    op = MD_MUL; operand1 = 32'hFFFF_FFFF; operand2 = 32'hFFFF_FFFF; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (4) tick;
    check("flush_calc/busy_before", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    check("flush_calc/busy", {31'b0, busy}, 32'd0);
    check("flush_calc/in_ready", {31'b0, in_ready}, 32'd1);
    check("flush_calc/result_kept", result, last_res);
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick;
      seen_valid = seen_valid | out_valid;
    end
    check("flush_calc/no_valid", {31'b0, seen_valid}, 32'd0);
    run_op("after_flush", MD_MULHU, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, 34, 0);

    // Flush and out_ready together in DONE: result dropped, unit idle, value kept.
    op = MD_DIVU; operand1 = 32'd100; operand2 = 32'd7; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick;
      lat++;
    end
    check("flush_done/latency", 32'(lat), 32'd34);
    flush = 1'b1; out_ready = 1'b1;
    tick;
    flush = 1'b0; out_ready = 1'b0;
    check("flush_done/out_valid", {31'b0, out_valid}, 32'd0);
    check("flush_done/in_ready", {31'b0, in_ready}, 32'd1);
    check("flush_done/result_kept", result, 32'd14);

    // Flush together with in_valid in IDLE: no accept.
    op = MD_DIV; operand1 = 32'd5; operand2 = 32'd0; in_valid = 1'b1; flush = 1'b1;
    tick;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle/busy", {31'b0, busy}, 32'd0);
    check("flush_idle/out_valid", {31'b0, out_valid}, 32'd0);
    tick;
    check("flush_idle/still_idle", {31'b0, in_ready}, 32'd1);
    check("flush_idle/result_kept", result, 32'd14);

    // Reset mid-CALC.
    op = MD_MULHU; operand1 = 32'hFFFF_FFFF; operand2 = 32'h1234_5678; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (3) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("rst_calc/in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_calc/out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_calc/busy", {31'b0, busy}, 32'd0);
    check("rst_calc/result", result, 32'd0);
    run_op("after_rst", MD_REMU, 32'd1000, 32'd7, 32'd6, 34, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
